// File: rtl/count_arbiter_if.sv
// Request/grant and counter-status bundle between control agents and count_arbiter.
// The sat status line exists only when COUNT_ARBITER_SAT_EN is defined.
interface count_arbiter_if #(
  parameter int CNT_W = 6,
  parameter int LEN_W = 4
);
  logic             req0;
  logic             dir0;
  logic [LEN_W-1:0] len0;
  logic             req1;
  logic             dir1;
  logic [LEN_W-1:0] len1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             trig;
  logic             ctrl;
  logic             done;
  logic [CNT_W-1:0] count;
`ifdef COUNT_ARBITER_SAT_EN
  logic             sat;
`endif

  modport master (
    output req0, dir0, len0, req1, dir1, len1,
`ifdef COUNT_ARBITER_SAT_EN
    input  sat,
`endif
    input  gnt0, gnt1, busy, trig, ctrl, done, count
  );

  modport slave (
    input  req0, dir0, len0, req1, dir1, len1,
`ifdef COUNT_ARBITER_SAT_EN
    output sat,
`endif
    output gnt0, gnt1, busy, trig, ctrl, done, count
  );
endinterface

// File: rtl/count_arbiter.sv
// Round-robin owner of a shared up/down step counter; one run of LEN steps per grant.
// Define COUNT_ARBITER_SAT_EN to saturate at the counter limits instead of wrapping.
module count_arbiter #(
  parameter int CNT_W = 6,
  parameter int LEN_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  count_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [LEN_W-1:0] remaining_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             busy_q;
  logic             trig_q;
  logic             ctrl_q;
  logic             done_q;
  logic             last_q;

  logic             pick1;
  logic             sel_dir;
  logic [LEN_W-1:0] sel_len;
  logic [CNT_W-1:0] count_next;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1   = bus.req1 && (!bus.req0 || !last_q);
  assign sel_dir = pick1 ? bus.dir1 : bus.dir0;
  assign sel_len = pick1 ? bus.len1 : bus.len0;

`ifdef COUNT_ARBITER_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic sat_q;
  logic suppress;

  always_comb begin
    suppress   = (ctrl_q && count_q == CNT_MAX) || (!ctrl_q && count_q == '0);
    count_next = count_q;
    if (!suppress)
      count_next = ctrl_q ? count_q + 1'b1 : count_q - 1'b1;
  end

  assign bus.sat = sat_q;
`else
  assign count_next = ctrl_q ? count_q + 1'b1 : count_q - 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      busy_q      <= 1'b0;
      trig_q      <= 1'b0;
      ctrl_q      <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b1;
`ifdef COUNT_ARBITER_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          trig_q <= 1'b0;
`ifdef COUNT_ARBITER_SAT_EN
          sat_q  <= 1'b0;
`endif
          if (bus.req0 || bus.req1) begin
            gnt0_q      <= !pick1;
            gnt1_q      <= pick1;
            ctrl_q      <= sel_dir;
            remaining_q <= sel_len;
            last_q      <= pick1;
            busy_q      <= 1'b1;
            // A zero-length run skips straight to the completion cycle.
            if (sel_len != '0) begin
              state  <= RUN;
              trig_q <= 1'b1;
            end else begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          count_q     <= count_next;
          remaining_q <= remaining_q - 1'b1;
`ifdef COUNT_ARBITER_SAT_EN
          sat_q       <= suppress;
`endif
          if (remaining_q == 1) begin
            state  <= DONE;
            trig_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          gnt0_q <= 1'b0;
          gnt1_q <= 1'b0;
          ctrl_q <= 1'b0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
`ifdef COUNT_ARBITER_SAT_EN
          sat_q  <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.busy  = busy_q;
  assign bus.trig  = trig_q;
  assign bus.ctrl  = ctrl_q;
  assign bus.done  = done_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_count_arbiter.sv
// Directed and randomized runs of count_arbiter checked cycle by cycle against a
// run-level model: winner by round-robin rule, count as start +/- steps.
module tb_count_arbiter;
  localparam int CNT_W = 6;
  localparam int LEN_W = 4;
  localparam int MODV  = 1 << CNT_W;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cnt_m    = 0;
  bit   last_m   = 1'b1;

  count_arbiter_if #(.CNT_W(CNT_W), .LEN_W(LEN_W)) bus ();

  count_arbiter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counter value after j steps of direction s starting from start.
  function automatic int val(input int start, input int s, input int j);
`ifdef COUNT_ARBITER_SAT_EN
    int v = start + s * j;
    if (v < 0) v = 0;
    if (v > MODV - 1) v = MODV - 1;
    return v;
`else
    return (((start + s * j) % MODV) + MODV) % MODV;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".gnt0"}, bus.gnt0, 0);
    chk({tag, ".gnt1"}, bus.gnt1, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".trig"}, bus.trig, 0);
    chk({tag, ".ctrl"}, bus.ctrl, 0);
    chk({tag, ".done"}, bus.done, 0);
    chk({tag, ".count"}, bus.count, cnt_m);
  endtask

  // Called one time unit after an edge while the DUT sits in IDLE.
  task automatic do_run(input bit r0, input bit d0, input int l0,
                        input bit r1, input bit d1, input int l1,
                        input bit mutate);
    bit w, dir;
    int len, s, start;
    bus.req0 = r0; bus.dir0 = d0; bus.len0 = LEN_W'(l0);
    bus.req1 = r1; bus.dir1 = d1; bus.len1 = LEN_W'(l1);
    w     = r1 && (!r0 || !last_m);
    dir   = w ? d1 : d0;
    len   = w ? l1 : l0;
    s     = dir ? 1 : -1;
    start = cnt_m;
    last_m = w;
    for (int k = 1; k <= len + 1; k++) begin
      tick();
      chk("gnt0", bus.gnt0, !w);
      chk("gnt1", bus.gnt1, w);
      chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
      chk("busy", bus.busy, 1);
      chk("trig", bus.trig, k <= len);
      chk("done", bus.done, k == len + 1);
      chk("ctrl", bus.ctrl, dir);
      chk("count", bus.count, val(start, s, k - 1));
`ifdef COUNT_ARBITER_SAT_EN
      chk("sat", bus.sat, (k >= 2) && (val(start, s, k - 1) == val(start, s, k - 2)));
`endif
      if (k == 1 && mutate) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.dir0 = ~bus.dir0; bus.dir1 = ~bus.dir1;
        bus.len0 = LEN_W'($urandom_range(15)); bus.len1 = LEN_W'($urandom_range(15));
      end
    end
    cnt_m = val(start, s, len);
    tick();
    check_idle("post_run");
  endtask

  initial begin
    reset = 1'b1;
    bus.req0 = 1'b0; bus.dir0 = 1'b0; bus.len0 = '0;
    bus.req1 = 1'b0; bus.dir1 = 1'b0; bus.len1 = '0;
    repeat (2) tick();
    check_idle("reset");
`ifdef COUNT_ARBITER_SAT_EN
    chk("reset.sat", bus.sat, 0);
`endif
    reset = 1'b0;
    tick();
    check_idle("idle0");

    do_run(1, 1, 5, 0, 0, 0, 0);   // 0 -> 5
    do_run(0, 0, 0, 1, 0, 3, 0);   // 5 -> 2
    do_run(0, 0, 0, 1, 0, 4, 0);   // crosses zero
    for (int i = 0; i < 4; i++) do_run(1, 1, 2, 1, 0, 2, 0);
    do_run(1, 1, 0, 0, 0, 0, 0);   // zero-length run
    do_run(1, 1, 8, 0, 0, 0, 1);   // inputs disturbed mid-run
    do_run(1, 0, 8, 0, 1, 3, 1);

    // Reset in the middle of an 8-step run.
    bus.req0 = 1'b1; bus.dir0 = 1'b1; bus.len0 = 4'd8; bus.req1 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("pre_reset.gnt0", bus.gnt0, 1);
      chk("pre_reset.count", bus.count, val(cnt_m, 1, k - 1));
    end
    bus.req0 = 1'b0;
    reset = 1'b1;
    tick();
    cnt_m = 0;
    last_m = 1'b1;
    check_idle("mid_reset");
    reset = 1'b0;
    tick();
    check_idle("after_reset");
    do_run(1, 1, 3, 1, 0, 3, 0);   // tie after reset goes to requester 0
    do_run(1, 1, 3, 1, 0, 3, 0);

    for (int i = 0; i < 30; i++) begin
      bit r0, r1;
      r0 = 1'($urandom_range(1));
      r1 = 1'($urandom_range(1));
      if (!r0 && !r1) r0 = 1'b1;
      do_run(r0, 1'($urandom_range(1)), $urandom_range(15),
             r1, 1'($urandom_range(1)), $urandom_range(15), 1'($urandom_range(1)));
    end

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (3) begin
      tick();
      check_idle("final_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/count_arbiter.md
Name: count_arbiter

Overview:
- Owns the shared 6-bit up/down step counter and arbitrates access to it between two requesters.
- Each requester asks for a "run" of LEN steps in a chosen direction.
- The block grants one requester at a time (round-robin) and steps the counter once per cycle for the granted length.
- Drives the trig/ctrl strobes and signals completion. Sits between control agents and any logic consuming the count value.

Parameters:
- CNT_W, 6: width of the shared counter.
- LEN_W, 4: width of the run-length request fields (max run = 2^LEN_W-1 steps).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 run request; level, held until done.
- dir0  input  1  requester 0 direction: 1 = up, 0 = down.
- len0  input  LEN_W  requester 0 step count.
- req1  input  1  requester 1 run request.
- dir1  input  1  requester 1 direction.
- len1  input  LEN_W  requester 1 step count.
- gnt0  output  1  requester 0 owns the counter.
- gnt1  output  1  requester 1 owns the counter.
- busy  output  1  a run is in progress (state != IDLE).
- trig  output  1  step strobe; high on every cycle the counter steps.
- ctrl  output  1  latched direction of the current run; 0 when idle.
- done  output  1  one-cycle pulse at end of run.
- count  output  CNT_W  shared counter value.

Behaviour:
- Reset (sync, active-high): state=IDLE, count=0, gnt0=gnt1=0, busy=trig=ctrl=done=0, rr pointer last=1 (so requester 0 wins first tie), remaining=0. Reset mid-run aborts the run; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req0/req1 sampled only here.
  - Single request: grant it.
  - Both requests: grant the id != last.
  - On the grant edge: gnt_x=1; latch dir_x into ctrl and len_x into remaining; last=x.
  - Next state is RUN if len_x != 0, else DONE.
  - No request: stay in IDLE.
- RUN:
  - trig=1 every cycle.
  - Each edge: count = count+1 (ctrl=1) or count-1 (ctrl=0), modulo 2^CNT_W; remaining decrements.
  - When remaining transitions 1->0, next state is DONE.
  - RUN lasts exactly len cycles; count changes exactly len times.
- DONE:
  - done=1 and gnt held for exactly one cycle; trig=0.
  - Next edge: IDLE, gnt cleared, ctrl=0.
- Latency:
  - Request seen at IDLE edge E0 → gnt/busy/trig high in cycle after E0.
  - First count change at E1; last count change at E_len.
  - done high in cycle after E_len.
  - Back-to-back grants are separated by at least one IDLE cycle.
- Boundaries:
  - Wrap: 63+1 → 0 and 0-1 → 63 (CNT_W=6).
  - len=0: grant and done with no step and no trig.
  - Requests, dir and len changing during RUN/DONE are ignored; values are latched at grant.
  - A requester that still has req high after DONE is re-arbitrated normally; round-robin prevents starvation when both requesters hold req.
  - gnt0 and gnt1 are never high simultaneously.

Optional Feature:
- Macro COUNT_ARBITER_SAT_EN.
- Defined: counter saturates instead of wrapping. Up at 2^CNT_W-1 holds the value; down at 0 holds the value. The run still consumes its full len cycles and trig stays high. An extra output port sat (1 bit, reset 0) pulses high on any cycle where a step was suppressed.
- Undefined: wrap-around as above; no sat port exists.

Test Plan:
- Reset, then req0=1, dir0=1, len0=5 → gnt0 high next cycle; trig high 5 cycles; count 0→5; done pulses once; gnt0 low the cycle after done.
- count=2, req1 dir1=0 len1=4 → count 2,1,0,63,62 (wrap); done pulse. With SAT_EN: count 2,1,0,0,0 and sat high for 2 cycles.
- req0 and req1 asserted together from reset, both held, len=2 → grants alternate 0,1,0,1; never both high; one IDLE cycle between runs.
- req0 len0=0 → gnt0 and done in the same cycle (one cycle after request); trig never high; count unchanged.
- During RUN of len 8, toggle req0 off and change dir0/len0 → run completes 8 steps in the original direction.
- Assert reset at step 3 of an 8-step run → next cycle count=0, gnt=0, busy=0, no done pulse; next arbitration grants requester 0 on a tie.
